// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_port_arbiter: two-port (CPU / UART loader) arbiter for one sync RAM.   |
// | Optional macro MEM_ARB_RR_EN selects round-robin; default is port-0 prio.  |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [DATA_W/8-1:0] m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                pick;
  logic                mem_en_q, mem_en_d;
  logic [BE_W-1:0]     mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic                m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                busy_q, busy_d;

  // RAM data arrives during RESP, so rdata passes it straight through then
  // and otherwise replays the value captured when RESP ended.
  assign m0_rdata  = m0_rvalid_q ? mem_dout : m0_rdata_q;
  assign m1_rdata  = m1_rvalid_q ? mem_dout : m1_rdata_q;
  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign busy      = busy_q;

  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
`else
    pick = ~m0_req;
`endif
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata;
    m1_rdata_d  = m1_rdata;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d    = ISSUE;
          last_gnt_d = pick;
          mem_en_d   = 1'b1;
          mem_we_d   = pick ? m1_we    : m0_we;
          mem_addr_d = pick ? m1_addr  : m0_addr;
          mem_din_d  = pick ? m1_wdata : m0_wdata;
          m0_gnt_d   = ~pick;
          m1_gnt_d   = pick;
        end
      end
      ISSUE: begin
        // mem_we_q still holds the latched enables of the access in flight
        if (mem_we_q == '0) begin
          state_d     = RESP;
          m0_rvalid_d = ~last_gnt_q;
          m1_rvalid_d = last_gnt_q;
        end else begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      busy_q      <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed bench for mem_port_arbiter with a RAM model. |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [13:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        busy;

  logic        pre_we;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] ram [0:16383];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-first, one-cycle read latency
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!(m0_gnt || m1_gnt) && waited < 6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_win;
    int w, gap;
`ifdef MEM_ARB_RR_EN
    exp_win = 4'b1010;
`else
    exp_win = 4'b0000;
`endif
    rst = 1'b0;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    mem_dout = 0;
    step(); step();

    // Reset state
    chk("rst_gnt",    {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
    chk("rst_mem",    {mem_en, mem_we, busy}, 0);
    chk("rst_addr",   {mem_addr, mem_din}, 0);
    chk("rst_rdata",  {m0_rdata, m1_rdata}, 0);
    rst = 1'b1;

    // Lone write from port 0
    m0_req = 1; m0_we = 4'hF; m0_addr = 14'h0010; m0_wdata = 32'hDEADBEEF;
    step();
    chk("wr_mem_en",   mem_en, 1);
    chk("wr_mem_we",   mem_we, 4'hF);
    chk("wr_mem_addr", mem_addr, 14'h0010);
    chk("wr_mem_din",  mem_din, 32'hDEADBEEF);
    chk("wr_gnt",      {m0_gnt, m1_gnt}, 2'b10);
    chk("wr_busy_iss", busy, 1);
    m0_req = 0; m0_we = 0;
    step();
    chk("wr_busy_end", busy, 0);
    chk("wr_en_end",   {mem_en, mem_we, m0_gnt}, 0);
    chk("wr_addr_hold", mem_addr, 14'h0010);
    chk("wr_ram",      ram[14'h0010], 32'hDEADBEEF);
    chk("wr_no_rvalid", {m0_rvalid, m1_rvalid}, 0);

    // Lone read from port 1
    pre_we = 1; pre_addr = 14'h0020; pre_data = 32'h12345678;
    step();
    pre_we = 0;
    m1_req = 1; m1_we = 0; m1_addr = 14'h0020;
    step();
    chk("rd_gnt",      {m0_gnt, m1_gnt}, 2'b01);
    chk("rd_mem",      {mem_en, mem_we, mem_addr}, {1'b1, 4'h0, 14'h0020});
    m1_req = 0;
    step();
    chk("rd_rvalid",   {m0_rvalid, m1_rvalid}, 2'b01);
    chk("rd_rdata",    m1_rdata, 32'h12345678);
    chk("rd_en_off",   {mem_en, m1_gnt, busy}, 3'b001);
    step();
    chk("rd_rvalid_end", {m0_rvalid, m1_rvalid, busy}, 0);
    chk("rd_rdata_hold", m1_rdata, 32'h12345678);

    // Contention after reset: both ports read continuously
    rst = 0; step(); rst = 1;
    m0_req = 1; m0_we = 0; m0_addr = 14'h0010;
    m1_req = 1; m1_we = 0; m1_addr = 14'h0020;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(w);
      chk("cont_gnt_seen", m0_gnt | m1_gnt, 1);
      chk("cont_winner", {m0_gnt, m1_gnt}, exp_win[k] ? 2'b01 : 2'b10);
      if (k > 0) chk("cont_spacing", w, 3);
    end
    m0_req = 0;
    wait_gnt(gap);
    chk("cont_after_drop", {m0_gnt, m1_gnt}, 2'b01);
    m1_req = 0;
    step();
    chk("cont_m1_rdata", {m1_rvalid, m1_rdata}, {1'b1, 32'h12345678});
    step();

    // Reset during ISSUE of an m0 read
    m0_req = 1; m0_we = 0; m0_addr = 14'h0020;
    step();
    chk("mid_gnt", m0_gnt, 1);
    m0_req = 0;
    #2 rst = 0;
    #1;
    chk("mid_rst_ctl",  {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy}, 0);
    chk("mid_rst_data", {mem_addr, mem_din, m0_rdata, m1_rdata}, 0);
    step();
    #3 rst = 1;
    m1_req = 1; m1_we = 4'hF; m1_addr = 14'h0030; m1_wdata = 32'hCAFEF00D;
    step();
    chk("mid_new_gnt",  {m0_gnt, m1_gnt, m0_rvalid}, 3'b010);
    chk("mid_new_mem",  {mem_en, mem_addr}, {1'b1, 14'h0030});
    m1_req = 0; m1_we = 0;
    step();
    chk("mid_no_rvalid", {m0_rvalid, m1_rvalid, busy}, 0);
    chk("mid_ram",      ram[14'h0030], 32'hCAFEF00D);

    // Request held for only the sampling edge
    m0_req = 1; m0_we = 0; m0_addr = 14'h0010;
    step();
    m0_req = 0;
    chk("drop_gnt",     {m0_gnt, m1_gnt}, 2'b10);
    step();
    chk("drop_rvalid",  {m0_rvalid, m1_rvalid}, 2'b10);
    chk("drop_rdata",   m0_rdata, 32'hDEADBEEF);
    step();
    chk("drop_end",     {m0_rvalid, busy}, 0);
    chk("drop_hold",    m0_rdata, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
